// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer and its op1bit step unit.
package shift_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_LOGICAL = 2'd0;
    localparam mode_t MODE_ARITH   = 2'd1;
    localparam mode_t MODE_ROTATE  = 2'd2;

    // Rotate takes priority over arithmetic fill.
    function automatic mode_t encode_mode(input logic sra, input logic rotate);
        if (rotate)
            return MODE_ROTATE;
        else if (sra)
            return MODE_ARITH;
        else
            return MODE_LOGICAL;
    endfunction

endpackage

// File: rtl/op1bit.sv
// Single-position right-shift step: logical, arithmetic or rotate; passes x through when op=0.
module op1bit
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             op,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = x;
        if (op) begin
            case (mode)
                MODE_ROTATE: y = {x[0], x[WIDTH-1:1]};
                MODE_ARITH:  y = {x[WIDTH-1], x[WIDTH-1:1]};
                default:     y = {1'b0, x[WIDTH-1:1]};
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative right shifter driving op1bit once per clock until shamt positions are applied.
// Define SHSEQ_DUAL_STEP_EN to chain two op1bit stages and retire two positions per cycle.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  logic             sra,
    input  logic             rotate,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [SHW-1:0]   cnt_q,   cnt_d;
    mode_t            mode_q,  mode_d;

    logic [WIDTH-1:0] step1;
    logic [WIDTH-1:0] step_out;
    logic [SHW-1:0]   step_cnt;

    op1bit #(.WIDTH(WIDTH)) u_step0 (
        .op   (1'b1),
        .mode (mode_q),
        .x    (data_q),
        .y    (step1)
    );

`ifdef SHSEQ_DUAL_STEP_EN
    logic             two_ok;
    logic [WIDTH-1:0] step2;

    // Second stage only acts while at least two positions remain.
    assign two_ok = (cnt_q > SHW'(1));

    op1bit #(.WIDTH(WIDTH)) u_step1 (
        .op   (two_ok),
        .mode (mode_q),
        .x    (step1),
        .y    (step2)
    );

    assign step_out = step2;
    assign step_cnt = two_ok ? SHW'(2) : SHW'(1);
`else
    assign step_out = step1;
    assign step_cnt = SHW'(1);
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d  = a;
                    cnt_d   = shamt;
                    mode_d  = encode_mode(sra, rotate);
                    state_d = (shamt != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                data_d = step_out;
                cnt_d  = cnt_q - step_cnt;
                if (cnt_q == step_cnt)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_LOGICAL;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign ready  = (state_q == S_IDLE);
    assign busy   = ~ready;
    assign done   = (state_q == S_DONE);
    assign result = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer; latency expectations follow SHSEQ_DUAL_STEP_EN when defined.
module tb_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        sra;
    logic        rotate;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.WIDTH(32), .SHW(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .shamt  (shamt),
        .sra    (sra),
        .rotate (rotate),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input int sh);
`ifdef SHSEQ_DUAL_STEP_EN
        return (sh + 1) / 2 + 1;
`else
        return sh + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, scramble inputs while busy, then check latency, result and ready return.
    task automatic run_op(input string tag, input logic [31:0] av, input int sh,
                          input logic s, input logic r, input logic [31:0] expv);
        int cyc;
        start = 1'b1; a = av; shamt = 5'(sh); sra = s; rotate = r;
        tick();
        start = 1'b0; a = ~av; shamt = 5'(sh + 3); sra = ~s; rotate = ~r;
        cyc = 1;
        while (!done && cyc < 64) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat(sh)));
        check({tag, " result"}, result, expv);
        check({tag, " ready in done"}, {31'b0, ready}, 32'd0);
        tick();
        check({tag, " ready back"}, {31'b0, ready}, 32'd1);
        check({tag, " done drop"}, {31'b0, done}, 32'd0);
        check({tag, " result held"}, result, expv);
        $display("op %s: a=%h shamt=%0d sra=%0b rot=%0b -> %h in %0d cycles",
                 tag, av, sh, s, r, result, cyc);
    endtask

    initial begin
        int done_cnt;
        int done_cyc;

        rst_n = 1'b0; start = 1'b0; a = '0; shamt = '0; sra = 1'b0; rotate = 1'b0;
        #12;
        check("reset ready", {31'b0, ready}, 32'd1);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'h0);
        rst_n = 1'b1;
        tick();

        run_op("logical4",  32'h12345678, 4,  1'b0, 1'b0, 32'h01234567);
        run_op("arith8",    32'h87654321, 8,  1'b1, 1'b0, 32'hFF876543);
        run_op("arith31",   32'h80000000, 31, 1'b1, 1'b0, 32'hFFFFFFFF);
        run_op("logical31", 32'h80000000, 31, 1'b0, 1'b0, 32'h00000001);
        run_op("rotate4",   32'hFEDCBA98, 4,  1'b1, 1'b1, 32'h8FEDCBA9);
        run_op("rotate31",  32'h00000001, 31, 1'b0, 1'b1, 32'h00000002);
        run_op("zero",      32'hC0FFEE01, 0,  1'b0, 1'b0, 32'hC0FFEE01);
        run_op("arith1",    32'h40000001, 1,  1'b1, 1'b0, 32'h20000000);

        // Start re-asserted during cycle 3 must be ignored.
        start = 1'b1; a = 32'hABCDEFFF; shamt = 5'd6; sra = 1'b0; rotate = 1'b0;
        tick();
        start = 1'b0;
        done_cnt = 0; done_cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c == 3) begin
                start = 1'b1; a = 32'h0;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check("busy done count", 32'(done_cnt), 32'd1);
        check("busy done cycle", 32'(done_cyc), 32'(exp_lat(6)));
        check("busy result", result, 32'h02AF37BF);
        $display("op busy: a=abcdefff shamt=6 -> %h, %0d done pulses", result, done_cnt);

        // Reset during an operation aborts without a done pulse.
        start = 1'b1; a = 32'h12345678; shamt = 5'd20; sra = 1'b0; rotate = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        check("pre-reset busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset ready", {31'b0, ready}, 32'd1);
        check("midreset busy", {31'b0, busy}, 32'd0);
        check("midreset result", result, 32'h0);
        check("midreset done", {31'b0, done}, 32'd0);
        tick();
        tick();
        check("held reset done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        tick();
        $display("op reset: aborted at cycle 5, result=%h", result);
        run_op("postreset", 32'hF0F0F0F0, 4, 1'b0, 1'b0, 32'h0F0F0F0F);

        // Back-to-back start on the cycle ready returns.
        run_op("b2b", 32'h00000080, 7, 1'b0, 1'b1, 32'h00000001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
